ti_sbox_round_sched: RTL and testbench

//  Schedules one nibble-serial S-box layer through a single shared, pipelined

---
 rtl/ti_sbox_round_sched_if.sv | 28 ++
 rtl/ti_sbox_round_sched.sv | 114 +++++++++++
 tb/tb_ti_sbox_round_sched.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ti_sbox_round_sched_if.sv
// Layer request/result bus plus the link to the shared TI S-box.
// slave  = the scheduler; master = round controller + S-box side.
interface ti_sbox_round_sched_if #(
  parameter int NSHARE  = 3,
  parameter int NIBBLES = 16
);
  localparam int SW = NSHARE * 4;
  localparam int W  = SW * NIBBLES;

  logic          start;
  logic [W-1:0]  state_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  state_out;
  logic [SW-1:0] sbox_din;
  logic          sbox_en;
  logic [SW-1:0] sbox_dout;

  modport slave (
    input  start, state_in, sbox_dout,
    output busy, done, state_out, sbox_din, sbox_en
  );

  modport master (
    output start, state_in, sbox_dout,
    input  busy, done, state_out, sbox_din, sbox_en
  );
endinterface

// File: rtl/ti_sbox_round_sched.sv
// Nibble-serial scheduler for one S-box layer through a shared pipelined
// TI S-box. Shares always travel together as one SW-bit slice and are
// never recombined here.
module ti_sbox_round_sched #(
  parameter int NSHARE   = 3,
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 2
) (
  input logic clk,
  input logic rst,
  ti_sbox_round_sched_if.slave bus
);
  localparam int SW = NSHARE * 4;
  localparam int W  = SW * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int DW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} st_t;

  st_t                 st;
  logic [W-1:0]        work;
  logic [CW-1:0]       icnt, ccnt, icnt_nx;
  logic [DW-1:0]       dcnt;
  logic [SBOX_LAT-1:0] vld_pipe;
  logic                busy_q, done_q, en_q;
  logic [SW-1:0]       din_q;
  logic [W-1:0]        sout_q;
  logic                last_issue, last_drain, cap;

  assign icnt_nx    = icnt + CW'(1);
  assign last_issue = (icnt == CW'(NIBBLES - 1));
  assign last_drain = (dcnt == DW'(SBOX_LAT - 1));
  // the tail of the valid pipe marks the cycle the S-box output belongs to a live slot
  assign cap        = en_q && vld_pipe[SBOX_LAT-1];

  // Sequencer: accept, issue nibbles from the work copy, drain with zeros, pulse done.
  // The first nibble is loaded into din_q at accept so the S-box sees it the very
  // next cycle; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      work   <= '0;
      icnt   <= '0;
      dcnt   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      en_q   <= 1'b0;
      din_q  <= '0;
    end else begin
      case (st)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            work   <= bus.state_in;
            icnt   <= '0;
            din_q  <= bus.state_in[SW-1:0];
            en_q   <= 1'b1;
            busy_q <= 1'b1;
            st     <= ISSUE;
          end
        end
        ISSUE: begin
          if (last_issue) begin
            din_q <= '0;
            dcnt  <= '0;
            st    <= DRAIN;
          end else begin
            icnt  <= icnt_nx;
            din_q <= work[int'(icnt_nx)*SW +: SW];
          end
        end
        DRAIN: begin
          if (last_drain) begin
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            st     <= FIN;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        FIN: begin
          done_q <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Track live slots through the S-box (only on enabled cycles) and write results back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      ccnt     <= '0;
      sout_q   <= '0;
    end else begin
      if (en_q) begin
        vld_pipe[0] <= (st == ISSUE);
        for (int i = 1; i < SBOX_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
      if (cap) begin
        sout_q[int'(ccnt)*SW +: SW] <= bus.sbox_dout;
        ccnt <= (ccnt == CW'(NIBBLES - 1)) ? '0 : ccnt + CW'(1);
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sbox_en   = en_q;
  assign bus.sbox_din  = din_q;
  assign bus.state_out = sout_q;
endmodule

// File: tb/tb_ti_sbox_round_sched.sv
// Scoreboard bench: main DUT (L=2) with an identity or masked-PRESENT S-box model,
// two side DUTs (L=1, L=4) with identity S-boxes sharing the same stimulus.
module tb_ti_sbox_round_sched;
  localparam int NS = 3;
  localparam int NB = 16;
  localparam int SW = NS * 4;
  localparam int W  = SW * NB;

  typedef struct {
    logic [W-1:0] sin;
    bit           masked;
    int           t0;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] sin;
  bit           masked;
  int           cyc = 0;
  int           n_chk = 0, n_err = 0;
  int           n_done2 = 0, en1 = 0, en4 = 0;
  int           free1 = 0, free2 = 0, free4 = 0;
  exp_t         q1[$], q2[$], q4[$];
  logic [SW-1:0] dq[$];

  logic [SW-1:0] p1 [0:0];
  logic [SW-1:0] p2 [0:1];
  logic [SW-1:0] p4 [0:3];

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  ti_sbox_round_sched_if #(.NSHARE(NS), .NIBBLES(NB)) b1 ();
  ti_sbox_round_sched_if #(.NSHARE(NS), .NIBBLES(NB)) b2 ();
  ti_sbox_round_sched_if #(.NSHARE(NS), .NIBBLES(NB)) b4 ();

  ti_sbox_round_sched #(.NSHARE(NS), .NIBBLES(NB), .SBOX_LAT(2)) u_dut (.clk(clk), .rst(rst), .bus(b2));
  ti_sbox_round_sched #(.NSHARE(NS), .NIBBLES(NB), .SBOX_LAT(1)) u_l1  (.clk(clk), .rst(rst), .bus(b1));
  ti_sbox_round_sched #(.NSHARE(NS), .NIBBLES(NB), .SBOX_LAT(4)) u_l4  (.clk(clk), .rst(rst), .bus(b4));

  assign b1.start = start;  assign b1.state_in = sin;
  assign b2.start = start;  assign b2.state_in = sin;
  assign b4.start = start;  assign b4.state_in = sin;
  assign b1.sbox_dout = p1[0];
  assign b2.sbox_dout = p2[1];
  assign b4.sbox_dout = p4[3];

  function automatic logic [3:0] present(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  // Masked S-box model: correct on the XOR of shares, freshly remasked each slot.
  function automatic logic [SW-1:0] sbox_masked(input logic [SW-1:0] x);
    logic [3:0] u, y, m1, m2;
    u  = x[3:0] ^ x[7:4] ^ x[11:8];
    y  = present(u);
    m1 = 4'($urandom);
    m2 = 4'($urandom);
    return {m2, m1, y ^ m1 ^ m2};
  endfunction

  function automatic logic [4*NB-1:0] unshare(input logic [W-1:0] s);
    logic [4*NB-1:0] r = '0;
    for (int k = 0; k < NB; k++)
      for (int sh = 0; sh < NS; sh++) r[k*4 +: 4] ^= s[(k*NS+sh)*4 +: 4];
    return r;
  endfunction

  function automatic logic [4*NB-1:0] layer(input logic [4*NB-1:0] u);
    logic [4*NB-1:0] r;
    for (int k = 0; k < NB; k++) r[k*4 +: 4] = present(u[k*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_state();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // External S-box pipelines: registers advance only when enabled.
  always_ff @(posedge clk) begin
    if (b2.sbox_en) begin
      p2[0] <= masked ? sbox_masked(b2.sbox_din) : b2.sbox_din;
      p2[1] <= p2[0];
    end
    if (b1.sbox_en) p1[0] <= b1.sbox_din;
    if (b4.sbox_en) begin
      p4[0] <= b4.sbox_din;
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic aux_done(input string nm, input exp_t e, input logic [W-1:0] so,
                          input int en, input int lat);
    chk({nm, "_lat"}, W'(cyc), W'(e.t0 + NB + lat + 1));
    chk({nm, "_out"}, so, e.sin);
    chk({nm, "_en_cycles"}, W'(en), W'(NB + lat));
  endtask

  // Output monitor: sample mid-cycle on the falling edge, pop and compare on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (b2.sbox_en) dq.push_back(b2.sbox_din);
        if (b1.sbox_en) en1++;
        if (b4.sbox_en) en4++;
        if (b2.done) begin
          n_done2++;
          chk("busy_in_fin", W'(b2.busy), '0);
          if (q2.size() == 0) chk("spurious_done", 1, 0);
          else begin
            e = q2.pop_front();
            chk("lat", W'(cyc), W'(e.t0 + NB + 3));
            if (e.masked) chk("sbox_layer", W'(unshare(b2.state_out)), W'(layer(unshare(e.sin))));
            else          chk("ident_out", b2.state_out, e.sin);
            chk("en_cycles", W'(dq.size()), W'(NB + 2));
            if (dq.size() == NB + 2) begin
              for (int i = 0; i < NB; i++) chk("din", W'(dq[i]), W'(e.sin[i*SW +: SW]));
              for (int i = NB; i < NB + 2; i++) chk("drain_din", W'(dq[i]), '0);
            end
          end
          dq.delete();
        end
        if (b1.done) begin
          if (q1.size() == 0) chk("l1_spurious_done", 1, 0);
          else aux_done("l1", q1.pop_front(), b1.state_out, en1, 1);
          en1 = 0;
        end
        if (b4.done) begin
          if (q4.size() == 0) chk("l4_spurious_done", 1, 0);
          else aux_done("l4", q4.pop_front(), b4.state_out, en4, 4);
          en4 = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drive start for one cycle; each DUT's expectation is queued only if that DUT is free.
  task automatic drive_start(input logic [W-1:0] s);
    exp_t e;
    start = 1'b1;
    sin   = s;
    e.sin = s; e.masked = masked; e.t0 = cyc;
    if (cyc >= free2) begin q2.push_back(e); free2 = cyc + NB + 4; end
    if (cyc >= free1) begin q1.push_back(e); free1 = cyc + NB + 3; end
    if (cyc >= free4) begin q4.push_back(e); free4 = cyc + NB + 6; end
    tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (q1.size() + q2.size() + q4.size()) != 0; i++) tick();
    if ((q1.size() + q2.size() + q4.size()) != 0) begin
      chk("timeout_pending", W'(q1.size() + q2.size() + q4.size()), '0);
      q1.delete(); q2.delete(); q4.delete();
    end
    tick();
  endtask

  initial begin
    logic [W-1:0] s;
    int d0;
    rst = 1'b1; start = 1'b0; sin = '0; masked = 1'b0;
    repeat (3) tick();
    chk("rst_busy", W'(b2.busy), '0);
    chk("rst_done", W'(b2.done), '0);
    chk("rst_en", W'(b2.sbox_en), '0);
    chk("rst_din", W'(b2.sbox_din), '0);
    chk("rst_out", b2.state_out, '0);
    rst = 1'b0;
    free1 = cyc; free2 = cyc; free4 = cyc;
    tick();

    // identity: every share of nibble k carries k
    for (int k = 0; k < NB; k++)
      for (int sh = 0; sh < NS; sh++) s[(k*NS+sh)*4 +: 4] = 4'(k);
    drive_start(s);
    start = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      drive_start(rand_state());
      start = 1'b0;
      wait_idle();
    end

    // start held high: accepts spaced by the layer period, nothing queued in between
    d0 = n_done2;
    for (int i = 0; i < 45; i++) drive_start(rand_state());
    start = 1'b0;
    wait_idle();
    chk("held_accepts", W'(n_done2 - d0), W'(3));

    // start pulsed while busy must be ignored
    d0 = n_done2;
    drive_start(rand_state());
    start = 1'b0;
    repeat (6) tick();
    drive_start(rand_state());
    start = 1'b0;
    wait_idle();
    chk("pulse_dones", W'(n_done2 - d0), W'(1));

    // reset in the middle of the issue phase (issue count 5)
    s = rand_state();
    drive_start(s);
    start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_din", W'(b2.sbox_din), W'(s[5*SW +: SW]));
    chk("pre_rst_out_nz", W'(b2.state_out != '0), W'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", W'(b2.busy), '0);
    chk("mid_rst_en", W'(b2.sbox_en), '0);
    chk("mid_rst_out", b2.state_out, '0);
    chk("mid_rst_done", W'(b2.done), '0);
    q1.delete(); q2.delete(); q4.delete(); dq.delete();
    en1 = 0; en4 = 0;
    tick();
    rst = 1'b0;
    free1 = cyc; free2 = cyc; free4 = cyc;
    tick();
    drive_start(rand_state());
    start = 1'b0;
    wait_idle();

    // masked PRESENT layers on random shares
    masked = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      drive_start(rand_state());
      start = 1'b0;
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
